// File: rtl/bus_seq_pkg.sv
// Shared slot map, slot type and window-check helpers for the bus sequencer.
package bus_seq_pkg;

  localparam int DEF_COUNT_WIDTH = 4;

  typedef logic [DEF_COUNT_WIDTH-1:0] slot_t;

  localparam slot_t PI_SEL_START  = slot_t'(0);
  localparam slot_t PI_STB        = slot_t'(1);
  localparam slot_t PI_SEL_END    = slot_t'(2);
  localparam slot_t CPU_SEL_START = slot_t'(12);
  localparam slot_t IO_SEL_START  = slot_t'(13);
  localparam slot_t CPU_STB       = slot_t'(14);
  localparam slot_t CPU_SEL_END   = slot_t'(15);

  function automatic bit window_ok(input int start, input int stb, input int stop);
    return (start <= stb) && (stb <= stop);
  endfunction

  function automatic bit windows_disjoint(input int s0, input int e0,
                                          input int s1, input int e1);
    return (e0 < s1) || (e1 < s0);
  endfunction

  function automatic bit window_inside(input int in_s, input int in_e,
                                       input int out_s, input int out_e);
    return (in_s >= out_s) && (in_e <= out_e) && (in_s <= in_e);
  endfunction

endpackage

// File: rtl/bus_seq_channel.sv
// One bus-master channel: select/strobe window decode from the upcoming slot,
// request grant latch and single-pulse acknowledge.
module bus_seq_channel
  import bus_seq_pkg::*;
#(
  parameter int                     COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter logic [COUNT_WIDTH-1:0] SEL_START   = '0,
  parameter logic [COUNT_WIDTH-1:0] SEL_END     = '0,
  parameter logic [COUNT_WIDTH-1:0] STB         = '0
) (
  input  logic                   clk16,
  input  logic                   reset_n,
  input  logic                   advance,
  input  logic [COUNT_WIDTH-1:0] slot_next,
  input  logic                   req,
  output logic                   select_next,
  output logic                   select,
  output logic                   strobe,
  output logic                   ack
);

  localparam logic [COUNT_WIDTH-1:0] SPAN = SEL_END - SEL_START;

  logic [COUNT_WIDTH-1:0] offset;
  logic                   in_win;
  logic                   at_start;
  logic                   at_stb;
  logic                   grant_reg;
  logic                   grant_eff;
  logic                   select_reg;
  logic                   strobe_reg;
  logic                   ack_reg;

  // Offset compare avoids a constant-true ">= 0" when the window starts at slot 0.
  assign offset      = slot_next - SEL_START;
  assign in_win      = (offset <= SPAN);
  assign at_start    = (slot_next == SEL_START);
  assign at_stb      = (slot_next == STB);
  assign grant_eff   = at_start ? req : grant_reg;
  assign select_next = in_win && grant_eff;

  always_ff @(posedge clk16 or negedge reset_n) begin
    if (!reset_n) begin
      grant_reg  <= 1'b0;
      select_reg <= 1'b0;
      strobe_reg <= 1'b0;
      ack_reg    <= 1'b0;
    end else if (advance) begin
      if (at_start) begin
        grant_reg <= req;
      end
      select_reg <= select_next;
      strobe_reg <= at_stb && grant_eff;
      ack_reg    <= at_stb && grant_eff;
    end else begin
      // A stretched strobe keeps its window but acknowledges only once.
      ack_reg <= 1'b0;
    end
  end

  assign select = select_reg;
  assign strobe = strobe_reg;
  assign ack    = ack_reg;

endmodule

// File: rtl/bus_sequencer.sv
// Parametrised bus slot sequencer: per-channel select/strobe/ack windows, IO
// sub-window and cycle marker. Define BUS_SEQ_WAIT_EN to enable strobe stretching.
module bus_sequencer
  import bus_seq_pkg::*;
#(
  parameter int                            COUNT_WIDTH  = DEF_COUNT_WIDTH,
  parameter int                            NUM_CH       = 2,
  parameter logic [NUM_CH*COUNT_WIDTH-1:0] CH_SEL_START = {CPU_SEL_START, PI_SEL_START},
  parameter logic [NUM_CH*COUNT_WIDTH-1:0] CH_SEL_END   = {CPU_SEL_END, PI_SEL_END},
  parameter logic [NUM_CH*COUNT_WIDTH-1:0] CH_STB       = {CPU_STB, PI_STB},
  parameter int                            IO_CH        = 1,
  parameter logic [COUNT_WIDTH-1:0]        IO_START     = IO_SEL_START,
  parameter logic [COUNT_WIDTH-1:0]        IO_END       = CPU_SEL_END,
  parameter int                            WAIT_MAX     = 7
) (
  input  logic                   clk16,
  input  logic                   reset_n,
  input  logic [NUM_CH-1:0]      ch_req,
`ifdef BUS_SEQ_WAIT_EN
  input  logic [NUM_CH-1:0]      ch_wait,
  output logic                   wait_timeout,
`endif
  output logic [NUM_CH-1:0]      ch_select,
  output logic [NUM_CH-1:0]      ch_strobe,
  output logic [NUM_CH-1:0]      ch_ack,
  output logic                   io_select,
  output logic                   cycle_start,
  output logic [COUNT_WIDTH-1:0] slot
);

  localparam logic [COUNT_WIDTH-1:0] IO_SPAN = IO_END - IO_START;

  logic [COUNT_WIDTH-1:0] count_reg;
  logic [COUNT_WIDTH-1:0] count_next;
  logic [COUNT_WIDTH-1:0] io_offset;
  logic [NUM_CH-1:0]      sel_next;
  logic                   advance;
  logic                   io_next;
  logic                   io_select_reg;
  logic                   cycle_start_reg;

  genvar gi, gj;

  generate
    if (NUM_CH < 1) begin : g_chk_num
      $error("bus_sequencer: NUM_CH must be at least 1");
    end
    if (IO_CH >= NUM_CH) begin : g_chk_io_ch
      $error("bus_sequencer: IO_CH must name an existing channel");
    end
    if (WAIT_MAX < 1) begin : g_chk_wait
      $error("bus_sequencer: WAIT_MAX must be at least 1");
    end
    if (!window_inside(int'(IO_START), int'(IO_END),
                       int'(CH_SEL_START[IO_CH*COUNT_WIDTH +: COUNT_WIDTH]),
                       int'(CH_SEL_END[IO_CH*COUNT_WIDTH +: COUNT_WIDTH]))) begin : g_chk_io_win
      $error("bus_sequencer: IO window must lie inside the IO channel window");
    end
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chk_ch
      if (!window_ok(int'(CH_SEL_START[gi*COUNT_WIDTH +: COUNT_WIDTH]),
                     int'(CH_STB[gi*COUNT_WIDTH +: COUNT_WIDTH]),
                     int'(CH_SEL_END[gi*COUNT_WIDTH +: COUNT_WIDTH]))) begin : g_bad_win
        $error("bus_sequencer: channel %0d needs start <= strobe <= end", gi);
      end
      for (gj = gi + 1; gj < NUM_CH; gj++) begin : g_pair
        if (!windows_disjoint(int'(CH_SEL_START[gi*COUNT_WIDTH +: COUNT_WIDTH]),
                              int'(CH_SEL_END[gi*COUNT_WIDTH +: COUNT_WIDTH]),
                              int'(CH_SEL_START[gj*COUNT_WIDTH +: COUNT_WIDTH]),
                              int'(CH_SEL_END[gj*COUNT_WIDTH +: COUNT_WIDTH]))) begin : g_overlap
          $error("bus_sequencer: windows of channels %0d and %0d overlap", gi, gj);
        end
      end
    end
  endgenerate

`ifdef BUS_SEQ_WAIT_EN
  localparam int                WAIT_W   = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              wait_timeout_reg;
  logic              stretch;
  logic              at_limit;

  // Strobes only exist for granted windows, so strobe alone qualifies the stretch.
  assign stretch  = |(ch_wait & ch_strobe);
  assign at_limit = (wait_cnt_reg == WAIT_LIM);
  assign advance  = !stretch || at_limit;

  always_ff @(posedge clk16 or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_reg     <= '0;
      wait_timeout_reg <= 1'b0;
    end else begin
      wait_cnt_reg     <= advance ? '0 : wait_cnt_reg + 1'b1;
      wait_timeout_reg <= stretch && at_limit;
    end
  end

  assign wait_timeout = wait_timeout_reg;
`else
  assign advance = 1'b1;
`endif

  assign count_next = advance ? count_reg + 1'b1 : count_reg;

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      bus_seq_channel #(
        .COUNT_WIDTH (COUNT_WIDTH),
        .SEL_START   (CH_SEL_START[gi*COUNT_WIDTH +: COUNT_WIDTH]),
        .SEL_END     (CH_SEL_END[gi*COUNT_WIDTH +: COUNT_WIDTH]),
        .STB         (CH_STB[gi*COUNT_WIDTH +: COUNT_WIDTH])
      ) u_channel (
        .clk16       (clk16),
        .reset_n     (reset_n),
        .advance     (advance),
        .slot_next   (count_next),
        .req         (ch_req[gi]),
        .select_next (sel_next[gi]),
        .select      (ch_select[gi]),
        .strobe      (ch_strobe[gi]),
        .ack         (ch_ack[gi])
      );
    end
  endgenerate

  assign io_offset = count_next - IO_START;
  assign io_next   = sel_next[IO_CH] && (io_offset <= IO_SPAN);

  // Everything decodes from count_next so outputs line up with slot.
  always_ff @(posedge clk16 or negedge reset_n) begin
    if (!reset_n) begin
      count_reg       <= '1;
      io_select_reg   <= 1'b0;
      cycle_start_reg <= 1'b0;
    end else if (advance) begin
      count_reg       <= count_next;
      io_select_reg   <= io_next;
      cycle_start_reg <= (count_next == '0);
    end
  end

  assign slot        = count_reg;
  assign io_select   = io_select_reg;
  assign cycle_start = cycle_start_reg;

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed self-checking bench for bus_sequencer (default map plus a 3-channel,
// 32-slot instance); stretch steps compile in with BUS_SEQ_WAIT_EN.
module tb_bus_sequencer;

  localparam logic [15:0] SEL0_M = 16'h0007;
  localparam logic [15:0] STB0_M = 16'h0002;
  localparam logic [15:0] SEL1_M = 16'hF000;
  localparam logic [15:0] STB1_M = 16'h4000;
  localparam logic [15:0] IO_M   = 16'hE000;
  localparam logic [15:0] CS_M   = 16'h0001;

  logic       clk16 = 1'b0;
  logic       reset_n;
  logic [1:0] ch_req;
  logic [1:0] ch_select, ch_strobe, ch_ack;
  logic       io_select, cycle_start;
  logic [3:0] slot;

  logic [2:0] req3;
  logic [2:0] sel3, stb3, ack3;
  logic       io3, cs3;
  logic [4:0] slot3;

`ifdef BUS_SEQ_WAIT_EN
  logic [1:0] ch_wait;
  logic       wait_timeout;
  logic [2:0] wait3;
  logic       timeout3;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit cnt3_en = 1'b0;
  int sel3_cnt[3];
  int stb3_cnt[3];
  int io3_cnt = 0;
  int cs3_cnt = 0;

  always #5 clk16 = ~clk16;

  bus_sequencer u_dut (
    .clk16       (clk16),
    .reset_n     (reset_n),
    .ch_req      (ch_req),
`ifdef BUS_SEQ_WAIT_EN
    .ch_wait     (ch_wait),
    .wait_timeout(wait_timeout),
`endif
    .ch_select   (ch_select),
    .ch_strobe   (ch_strobe),
    .ch_ack      (ch_ack),
    .io_select   (io_select),
    .cycle_start (cycle_start),
    .slot        (slot)
  );

  bus_sequencer #(
    .COUNT_WIDTH (5),
    .NUM_CH      (3),
    .CH_SEL_START({5'd24, 5'd10, 5'd0}),
    .CH_SEL_END  ({5'd31, 5'd12, 5'd3}),
    .CH_STB      ({5'd28, 5'd11, 5'd2}),
    .IO_CH       (2),
    .IO_START    (5'd25),
    .IO_END      (5'd30)
  ) u_dut3 (
    .clk16       (clk16),
    .reset_n     (reset_n),
    .ch_req      (req3),
`ifdef BUS_SEQ_WAIT_EN
    .ch_wait     (wait3),
    .wait_timeout(timeout3),
`endif
    .ch_select   (sel3),
    .ch_strobe   (stb3),
    .ch_ack      (ack3),
    .io_select   (io3),
    .cycle_start (cs3),
    .slot        (slot3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) begin
      $display("check %s obs=%0h exp=%0h ok", tag, obs, exp);
    end else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] obs_vec();
    return {ch_select, ch_strobe, ch_ack, io_select, cycle_start};
  endfunction

  function automatic logic [7:0] exp_vec(input int s, input logic [1:0] g);
    logic [3:0] idx;
    idx = 4'(s);
    return {SEL1_M[idx] & g[1], SEL0_M[idx] & g[0],
            STB1_M[idx] & g[1], STB0_M[idx] & g[0],
            STB1_M[idx] & g[1], STB0_M[idx] & g[0],
            IO_M[idx] & g[1], CS_M[idx]};
  endfunction

  task automatic step();
    @(posedge clk16);
    @(negedge clk16);
    if (cnt3_en) begin
      for (int i = 0; i < 3; i++) begin
        sel3_cnt[i] += int'(sel3[i]);
        stb3_cnt[i] += int'(stb3[i]);
      end
      io3_cnt += int'(io3);
      cs3_cnt += int'(cs3);
    end
  endtask

  // Runs one 16-slot cycle from slot 15; g is the grant pattern for this cycle.
  task automatic run_cycle(input logic [1:0] g, input int drop_at);
    for (int s = 0; s < 16; s++) begin
      step();
      check($sformatf("slot_s%0d", s), 32'(slot), 32'(s));
      check($sformatf("outs_s%0d_g%b", s, g), 32'(obs_vec()), 32'(exp_vec(s, g)));
      if (s == drop_at) ch_req[1] = 1'b0;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    ch_req  = 2'b11;
    req3    = 3'b111;
`ifdef BUS_SEQ_WAIT_EN
    ch_wait = 2'b00;
    wait3   = 3'b000;
`endif
    for (int i = 0; i < 3; i++) begin
      sel3_cnt[i] = 0;
      stb3_cnt[i] = 0;
    end

    // Reset state
    repeat (3) @(negedge clk16);
    check("reset_slot", 32'(slot), 32'hF);
    check("reset_outs", 32'(obs_vec()), 32'h0);
    check("reset_slot3", 32'(slot3), 32'h1F);

    // Legacy waveform, two full cycles, with the 32-slot instance counted alongside
    reset_n = 1'b1;
    cnt3_en = 1'b1;
    run_cycle(2'b11, -1);
    run_cycle(2'b11, -1);
    cnt3_en = 1'b0;
    check("w5_slot_end", 32'(slot3), 32'd31);
    check("w5_sel0_cnt", 32'(sel3_cnt[0]), 32'd4);
    check("w5_sel1_cnt", 32'(sel3_cnt[1]), 32'd3);
    check("w5_sel2_cnt", 32'(sel3_cnt[2]), 32'd8);
    check("w5_stb0_cnt", 32'(stb3_cnt[0]), 32'd1);
    check("w5_stb1_cnt", 32'(stb3_cnt[1]), 32'd1);
    check("w5_stb2_cnt", 32'(stb3_cnt[2]), 32'd1);
    check("w5_io_cnt", 32'(io3_cnt), 32'd6);
    check("w5_cs_cnt", 32'(cs3_cnt), 32'd1);

    // Channel 0 not requesting
    ch_req = 2'b10;
    run_cycle(2'b10, -1);

    // Channel 1 request drops mid-window, then stays low for a full cycle
    ch_req = 2'b11;
    run_cycle(2'b11, 13);
    run_cycle(2'b01, -1);
    ch_req = 2'b11;
    run_cycle(2'b11, -1);

    // Reset asserted in slot 7, held 3 clocks
    repeat (8) step();
    check("pre_rst7_slot", 32'(slot), 32'd7);
    reset_n = 1'b0;
    #1;
    check("rst7_slot", 32'(slot), 32'hF);
    check("rst7_outs", 32'(obs_vec()), 32'h0);
    repeat (3) @(posedge clk16);
    @(negedge clk16);
    check("rst7_hold_slot", 32'(slot), 32'hF);
    reset_n = 1'b1;
    run_cycle(2'b11, -1);

    // Reset asserted in slot 14 while channel 1 outputs are active
    repeat (15) step();
    check("pre_rst14_outs", 32'(obs_vec()), 32'(exp_vec(14, 2'b11)));
    reset_n = 1'b0;
    #1;
    check("rst14_outs", 32'(obs_vec()), 32'h0);
    check("rst14_slot", 32'(slot), 32'hF);
    @(negedge clk16);
    reset_n = 1'b1;
    run_cycle(2'b11, -1);

`ifdef BUS_SEQ_WAIT_EN
    // Stretch slot 14 by three clocks: 19-clock cycle, single ack
    repeat (15) step();
    check("wt_slot14", 32'(slot), 32'd14);
    check("wt_ack_first", 32'(ch_ack), 32'h2);
    ch_wait = 2'b10;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("wt_hold%0d_slot", k), 32'(slot), 32'd14);
      check($sformatf("wt_hold%0d_vec", k), 32'(obs_vec()), 32'b10_10_00_1_0);
    end
    ch_wait = 2'b00;
    step();
    check("wt_rel_slot", 32'(slot), 32'd15);
    check("wt_rel_timeout", 32'(wait_timeout), 32'h0);
    step();
    check("wt_wrap_slot", 32'(slot), 32'd0);
    check("wt_wrap_cs", 32'(cycle_start), 32'h1);

    // Wait held past the limit: 8 clocks in slot 14, one timeout pulse
    repeat (14) step();
    check("to_slot14", 32'(slot), 32'd14);
    ch_wait = 2'b10;
    for (int k = 0; k < 7; k++) begin
      step();
      check($sformatf("to_hold%0d_slot", k), 32'(slot), 32'd14);
      check($sformatf("to_hold%0d_tmo_ack", k), 32'({wait_timeout, ch_ack}), 32'h0);
    end
    step();
    check("to_adv_slot", 32'(slot), 32'd15);
    check("to_adv_timeout", 32'(wait_timeout), 32'h1);
    step();
    check("to_after_slot", 32'(slot), 32'd0);
    check("to_after_timeout", 32'(wait_timeout), 32'h0);
    ch_wait = 2'b00;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
